// File: rtl/gigatron_pad_pkg.sv
// rtl/gigatron_pad_pkg.sv - shared constants and state type for the Famiclone pad responder
package gigatron_pad_pkg;

    localparam int PAD_BITS = 8;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } pad_state_t;

endpackage

// File: rtl/pad_debounce.sv
// rtl/pad_debounce.sv - two-flop synchroniser and counter debouncer for one active-low button
module pad_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic stable_n
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser resets to "released" so power-up never counts toward a false press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stable_n = stable_q;

endmodule

// File: rtl/famiclone_pad_responder.sv
// rtl/famiclone_pad_responder.sv - 4021-style NES pad emulation answering Gigatron SER_LATCH/SER_PULSE
module famiclone_pad_responder
    import gigatron_pad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] buttons_n,
    input  logic       ser_latch,
    input  logic       ser_pulse,
    output logic       ser_data,
    output logic [7:0] pad_state,
    output logic [3:0] bit_count,
    output logic       frame_done
);

    logic [PAD_BITS-1:0] stable_n;

    for (genvar g = 0; g < PAD_BITS; g++) begin : g_btn
        pad_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (CLOCK_50),
            .rst_n    (reset_n),
            .raw_n    (buttons_n[g]),
            .stable_n (stable_n[g])
        );
    end

    logic [SYNC_STAGES-1:0] latch_sync_q, pulse_sync_q;
    logic                   latch_hist_q, pulse_hist_q;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            latch_sync_q <= '0;
            pulse_sync_q <= '0;
            latch_hist_q <= 1'b0;
            pulse_hist_q <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], ser_latch};
            pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], ser_pulse};
            latch_hist_q <= latch_sync_q[SYNC_STAGES-1];
            pulse_hist_q <= pulse_sync_q[SYNC_STAGES-1];
        end
    end

    logic latch_rise, latch_fall, pulse_rise;
    assign latch_rise =  latch_sync_q[SYNC_STAGES-1] & ~latch_hist_q;
    assign latch_fall = ~latch_sync_q[SYNC_STAGES-1] &  latch_hist_q;
    assign pulse_rise =  pulse_sync_q[SYNC_STAGES-1] & ~pulse_hist_q;

    pad_state_t          state_q;
    logic [PAD_BITS-1:0] shift_q;
    logic                ser_data_q;
    logic [3:0]          bit_count_q;
    logic                frame_done_q;

    // A latch rise outranks everything else, including a pulse edge in the same cycle.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_q      <= '1;
            ser_data_q   <= 1'b1;
            bit_count_q  <= 4'd0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (latch_rise) begin
                state_q     <= LOAD;
                shift_q     <= stable_n;
                ser_data_q  <= stable_n[BTN_A];
                bit_count_q <= 4'd0;
            end else begin
                case (state_q)
                    IDLE: ser_data_q <= 1'b1;
                    LOAD: begin
                        if (latch_fall) begin
                            state_q <= SHIFT;
                        end else begin
                            shift_q     <= stable_n;
                            ser_data_q  <= shift_q[PAD_BITS-1];
                            bit_count_q <= 4'd0;
                        end
                    end
                    SHIFT: begin
                        if (pulse_rise) begin
                            shift_q     <= {shift_q[PAD_BITS-2:0], 1'b1};
                            ser_data_q  <= shift_q[PAD_BITS-2];
                            bit_count_q <= bit_count_q + 4'd1;
                            if (bit_count_q == 4'(PAD_BITS - 1)) begin
                                state_q      <= DONE;
                                frame_done_q <= 1'b1;
                                ser_data_q   <= 1'b1;
                            end
                        end
                    end
                    DONE:    ser_data_q <= 1'b1;
                    default: state_q    <= IDLE;
                endcase
            end
        end
    end

    assign ser_data   = ser_data_q;
    assign pad_state  = stable_n;
    assign bit_count  = bit_count_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_famiclone_pad_responder.sv
// tb/tb_famiclone_pad_responder.sv - directed self-checking bench for famiclone_pad_responder
module tb_famiclone_pad_responder;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] buttons_n = 8'hFF;
    logic       ser_latch = 1'b0;
    logic       ser_pulse = 1'b0;
    logic       ser_data;
    logic [7:0] pad_state;
    logic [3:0] bit_count;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_cnt = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    famiclone_pad_responder #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .buttons_n  (buttons_n),
        .ser_latch  (ser_latch),
        .ser_pulse  (ser_pulse),
        .ser_data   (ser_data),
        .pad_state  (pad_state),
        .bit_count  (bit_count),
        .frame_done (frame_done)
    );

    always @(negedge CLOCK_50) if (frame_done) frame_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic do_latch();
        ser_latch = 1'b1;
        tick(10);
        ser_latch = 1'b0;
        tick(10);
    endtask

    task automatic do_pulse();
        ser_pulse = 1'b1;
        tick(10);
        ser_pulse = 1'b0;
        tick(10);
    endtask

    logic exp_a7e [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        tick(3);
        check_eq("reset_ser_data", 32'(ser_data), 32'd1);
        check_eq("reset_pad_state", 32'(pad_state), 32'hFF);
        check_eq("reset_bit_count", 32'(bit_count), 32'd0);
        check_eq("reset_frame_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Basic read, A and Right pressed
        buttons_n = 8'b0111_1110;
        tick(20);
        check_eq("t1_pad_state", 32'(pad_state), 32'h7E);
        check_eq("t1_idle_ser_data", 32'(ser_data), 32'd1);
        do_latch();
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t1_bit%0d", i), 32'(ser_data), 32'(exp_a7e[i]));
            do_pulse();
        end
        check_eq("t1_tail_ser_data", 32'(ser_data), 32'd1);
        check_eq("t1_bit_count", 32'(bit_count), 32'd8);
        check_eq("t1_frames", 32'(frame_cnt), 32'd1);

        // Extra pulses past the end of the frame
        repeat (4) do_pulse();
        check_eq("t2_ser_data", 32'(ser_data), 32'd1);
        check_eq("t2_bit_count", 32'(bit_count), 32'd8);
        check_eq("t2_frames", 32'(frame_cnt), 32'd1);

        // Debounce: bounce A, then hold it pressed
        buttons_n = 8'hFF;
        tick(10);
        check_eq("t3_release", 32'(pad_state), 32'hFF);
        for (int p = 0; p < 20; p++) begin
            buttons_n[7] = p[0];
            tick(2);
            check_eq($sformatf("t3_bounce%0d", p), 32'(pad_state[7]), 32'd1);
        end
        buttons_n[7] = 1'b0;
        tick(5);
        check_eq("t3_hold_early", 32'(pad_state[7]), 32'd1);
        tick(1);
        check_eq("t3_hold_taken", 32'(pad_state[7]), 32'd0);

        // Restart mid-frame; Start pressed so bit 3 of the stream is 0
        buttons_n = 8'hEF;
        tick(10);
        check_eq("t4_pad_state", 32'(pad_state), 32'hEF);
        do_latch();
        repeat (3) do_pulse();
        check_eq("t4_bit_count3", 32'(bit_count), 32'd3);
        check_eq("t4_start_bit", 32'(ser_data), 32'd0);
        buttons_n = 8'hFF;
        tick(10);
        check_eq("t4_frame_frozen", 32'(ser_data), 32'd0);
        ser_latch = 1'b1;
        tick(2);
        check_eq("t4_latency_hold_cnt", 32'(bit_count), 32'd3);
        check_eq("t4_latency_hold_data", 32'(ser_data), 32'd0);
        tick(1);
        check_eq("t4_relatch_data", 32'(ser_data), 32'd1);
        check_eq("t4_relatch_cnt", 32'(bit_count), 32'd0);
        tick(7);
        ser_latch = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t4_bit%0d", i), 32'(ser_data), 32'd1);
            do_pulse();
        end
        check_eq("t4_bit_count", 32'(bit_count), 32'd8);
        check_eq("t4_frames", 32'(frame_cnt), 32'd2);

        // Collisions: latch rise with pulse rise, then latch fall with pulse rise
        do_latch();
        repeat (2) do_pulse();
        check_eq("t5_bit_count2", 32'(bit_count), 32'd2);
        ser_latch = 1'b1;
        ser_pulse = 1'b1;
        tick(10);
        check_eq("t5_collide_cnt", 32'(bit_count), 32'd0);
        ser_pulse = 1'b0;
        tick(10);
        ser_latch = 1'b0;
        ser_pulse = 1'b1;
        tick(10);
        ser_pulse = 1'b0;
        tick(10);
        check_eq("t5_fall_pulse_cnt", 32'(bit_count), 32'd0);
        repeat (8) do_pulse();
        check_eq("t5_bit_count", 32'(bit_count), 32'd8);
        check_eq("t5_frames", 32'(frame_cnt), 32'd3);

        // Reset mid-shift with Down pressed on the line
        buttons_n = 8'hFB;
        tick(10);
        do_latch();
        repeat (5) do_pulse();
        check_eq("t6_bit_count5", 32'(bit_count), 32'd5);
        check_eq("t6_down_bit", 32'(ser_data), 32'd0);
        reset_n = 1'b0;
        #2;
        check_eq("t6_rst_ser_data", 32'(ser_data), 32'd1);
        check_eq("t6_rst_bit_count", 32'(bit_count), 32'd0);
        check_eq("t6_rst_pad_state", 32'(pad_state), 32'hFF);
        tick(3);
        reset_n = 1'b1;
        repeat (2) do_pulse();
        check_eq("t6_idle_ser_data", 32'(ser_data), 32'd1);
        check_eq("t6_idle_bit_count", 32'(bit_count), 32'd0);
        check_eq("t6_pad_relearn", 32'(pad_state), 32'hFB);
        check_eq("t6_frames", 32'(frame_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
